// File: rtl/press_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : press_pkg
//  Description : Shared types and default thresholds for the push-button
//                press classifier (10 kHz tick domain).
//                Contents:
//                  press_state_t      per-channel FSM state encoding
//                  c_def_*            default parameter values for a 10 kHz
//                                     tick (3 s long press, 250 ms repeat)
//  Revision    : 1.0 - initial release
// ============================================================================
package press_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPORT = 2'd2
    } press_state_t;

    localparam int unsigned c_tick_hz            = 10000;
    localparam int unsigned c_def_n_ch           = 4;
    localparam int unsigned c_def_cnt_w          = 15;
    localparam int unsigned c_def_short_min      = 3;
    localparam int unsigned c_def_long_min       = 3 * c_tick_hz;
    localparam int unsigned c_def_repeat_period  = c_tick_hz / 4;

endpackage : press_pkg
`default_nettype wire

// File: rtl/press_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier_if
//  Description : Key-input / event-output bundle of the press classifier.
//                Signals (all N_CH wide, bit i = channel i):
//                  key_in        raw key levels, 1 = pressed (async to clk)
//                  short_pulse   1-cycle short-press event
//                  long_pulse    1-cycle long-press event
//                  long_held     level, key still down past long threshold
//                  repeat_pulse  1-cycle auto-repeat event
//                Modports: master = key source / event consumer,
//                          slave  = classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface press_classifier_if #(
    parameter int unsigned N_CH = 4
) ();

    logic [N_CH-1:0] key_in;
    logic [N_CH-1:0] short_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] long_held;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output key_in,
        input  short_pulse,
        input  long_pulse,
        input  long_held,
        input  repeat_pulse
    );

    modport slave (
        input  key_in,
        output short_pulse,
        output long_pulse,
        output long_held,
        output repeat_pulse
    );

endinterface : press_classifier_if
`default_nettype wire

// File: rtl/press_classifier_ch.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier_ch
//  Description : One key channel: 2-flop synchroniser, IDLE/HELD/REPORT FSM
//                with saturating hold counter, classification on release.
//                Optional auto-repeat generator (macro PRESS_REPEAT_EN).
//                Ports:
//                  clk_10000Hz   tick clock, posedge
//                  rst_n         asynchronous active-low reset
//                  key_in        raw key level
//                  short_pulse   1-cycle, released with SHORT_MIN <= held < LONG_MIN
//                  long_pulse    1-cycle, released with held >= LONG_MIN
//                  long_held     level, in HELD with count >= LONG_MIN
//                  repeat_pulse  1-cycle auto-repeat (0 without PRESS_REPEAT_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module press_classifier_ch
    import press_pkg::*;
#(
    parameter int unsigned CNT_W         = c_def_cnt_w,
    parameter int unsigned SHORT_MIN     = c_def_short_min,
    parameter int unsigned LONG_MIN      = c_def_long_min,
    parameter int unsigned REPEAT_PERIOD = c_def_repeat_period
) (
    input  wire logic clk_10000Hz,
    input  wire logic rst_n,
    input  wire logic key_in,
    output logic      short_pulse,
    output logic      long_pulse,
    output logic      long_held,
    output logic      repeat_pulse
);

    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_short_min = CNT_W'(SHORT_MIN);
    localparam logic [CNT_W-1:0] c_long_min  = CNT_W'(LONG_MIN);

    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("press_classifier_ch: REPEAT_PERIOD must be at least 1");
    end

    logic [1:0]       r_sync;
    press_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_long_held;

    logic             w_ks;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_ks      = r_sync[1];
    // Saturate instead of wrapping so a very long hold is never reclassified.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk_10000Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= 2'b00;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
            r_long_held <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_in};
            r_short <= 1'b0;
            r_long  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt       <= '0;
                    r_long_held <= 1'b0;
                    if (w_ks) begin
                        r_state <= HELD;
                        r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                HELD: begin
                    if (w_ks) begin
                        r_cnt       <= w_cnt_inc;
                        r_long_held <= (r_cnt >= c_long_min);
                    end else begin
                        // Pulses are registered here so they are high exactly
                        // during the single REPORT cycle.
                        r_state     <= REPORT;
                        r_long_held <= 1'b0;
                        r_long      <= (r_cnt >= c_long_min);
                        r_short     <= (r_cnt >= c_short_min) && (r_cnt < c_long_min);
                    end
                end
                REPORT: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign short_pulse = r_short;
    assign long_pulse  = r_long;
    assign long_held   = r_long_held;

`ifdef PRESS_REPEAT_EN
    localparam int unsigned         c_rep_w    = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
    localparam logic [c_rep_w-1:0]  c_rep_last = c_rep_w'(REPEAT_PERIOD - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_repeat;

    // First pulse coincides with the count reaching LONG_MIN; later pulses
    // are paced by cycles spent held, so counter saturation does not stop them.
    always_ff @(posedge clk_10000Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (r_state == HELD && w_ks) begin
                if (r_cnt < c_long_min && w_cnt_inc == c_long_min) begin
                    r_repeat  <= 1'b1;
                    r_rep_cnt <= '0;
                end else if (r_cnt >= c_long_min) begin
                    if (r_rep_cnt == c_rep_last) begin
                        r_repeat  <= 1'b1;
                        r_rep_cnt <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end
            end else begin
                r_rep_cnt <= '0;
            end
        end
    end

    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule : press_classifier_ch
`default_nettype wire

// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier
//  Description : N-channel push-button press classifier on the 10 kHz tick.
//                Each channel is an independent press_classifier_ch; this
//                level only fans out the keys and gathers the event bits.
//                Optional build macro: PRESS_REPEAT_EN (auto-repeat pulses).
//                Ports:
//                  clk_10000Hz   tick clock, posedge
//                  rst_n         asynchronous active-low reset
//                  bus           press_classifier_if.slave (key_in in,
//                                short/long/repeat pulses and long_held out)
//  Revision    : 1.0 - initial release
// ============================================================================
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned N_CH          = c_def_n_ch,
    parameter int unsigned CNT_W         = c_def_cnt_w,
    parameter int unsigned SHORT_MIN     = c_def_short_min,
    parameter int unsigned LONG_MIN      = c_def_long_min,
    parameter int unsigned REPEAT_PERIOD = c_def_repeat_period
) (
    input  wire logic         clk_10000Hz,
    input  wire logic         rst_n,
    press_classifier_if.slave bus
);

    localparam longint unsigned c_cnt_max = (64'd1 << CNT_W) - 64'd1;

    if ((SHORT_MIN == 0) || (SHORT_MIN >= LONG_MIN) || (64'(LONG_MIN) > c_cnt_max)) begin : g_bad_thresholds
        $error("press_classifier: need 1 <= SHORT_MIN < LONG_MIN <= 2^CNT_W-1");
    end

    logic [N_CH-1:0] w_short;
    logic [N_CH-1:0] w_long;
    logic [N_CH-1:0] w_held;
    logic [N_CH-1:0] w_repeat;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        press_classifier_ch #(
            .CNT_W         (CNT_W),
            .SHORT_MIN     (SHORT_MIN),
            .LONG_MIN      (LONG_MIN),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_10000Hz  (clk_10000Hz),
            .rst_n        (rst_n),
            .key_in       (bus.key_in[g]),
            .short_pulse  (w_short[g]),
            .long_pulse   (w_long[g]),
            .long_held    (w_held[g]),
            .repeat_pulse (w_repeat[g])
        );
    end

    assign bus.short_pulse  = w_short;
    assign bus.long_pulse   = w_long;
    assign bus.long_held    = w_held;
    assign bus.repeat_pulse = w_repeat;

endmodule : press_classifier
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_press_classifier
//  Description : Self-checking bench for press_classifier (2 channels,
//                8-bit counter, short >= 3, long >= 20, repeat every 5).
//                Stimulus pushes expected output events (cycle + values)
//                into a queue; a negedge monitor pops and compares every
//                cycle in which the DUT shows a pulse or a long_held change.
//                Honours PRESS_REPEAT_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_press_classifier;

    localparam int C_NCH   = 2;
    localparam int C_CNTW  = 8;
    localparam int C_SHORT = 3;
    localparam int C_LONG  = 20;
    localparam int C_REP   = 5;

    typedef struct {
        int         cyc;
        logic [1:0] sp;
        logic [1:0] lp;
        logic [1:0] rp;
        logic [1:0] lh;
    } ev_t;

    logic clk_10000Hz = 1'b0;
    logic rst_n       = 1'b0;
    int   cyc         = 0;
    int   n_checks    = 0;
    int   n_pass      = 0;
    ev_t  exp_q[$];
    logic [1:0] prev_lh = 2'b00;

    press_classifier_if #(.N_CH(C_NCH)) bus ();

    press_classifier #(
        .N_CH          (C_NCH),
        .CNT_W         (C_CNTW),
        .SHORT_MIN     (C_SHORT),
        .LONG_MIN      (C_LONG),
        .REPEAT_PERIOD (C_REP)
    ) dut (
        .clk_10000Hz (clk_10000Hz),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    always #5 clk_10000Hz = ~clk_10000Hz;

    always @(posedge clk_10000Hz) cyc <= cyc + 1;

    // Insert an expected event in cycle order, merging events of one cycle.
    function automatic void add_ev(input int c, input logic [1:0] sp, input logic [1:0] lp,
                                   input logic [1:0] rp, input logic [1:0] lh);
        ev_t e;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == c) begin
                exp_q[i].sp |= sp;
                exp_q[i].lp |= lp;
                exp_q[i].rp |= rp;
                exp_q[i].lh |= lh;
                return;
            end
            if (exp_q[i].cyc > c) begin
                e = '{c, sp, lp, rp, lh};
                exp_q.insert(i, e);
                return;
            end
        end
        e = '{c, sp, lp, rp, lh};
        exp_q.push_back(e);
    endfunction

    // Monitor: any pulse or long_held edge must match the head of the queue;
    // an expected event whose cycle has passed unseen is reported as missed.
    always @(negedge clk_10000Hz) begin
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missed_event: expected event at cycle %0d (sp=%b lp=%b rp=%b lh=%b) never seen",
                     e.cyc, e.sp, e.lp, e.rp, e.lh);
        end
        if (bus.short_pulse != 0 || bus.long_pulse != 0 || bus.repeat_pulse != 0 ||
            bus.long_held != prev_lh) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: cycle %0d got sp=%b lp=%b rp=%b lh=%b, required none",
                         cyc, bus.short_pulse, bus.long_pulse, bus.repeat_pulse, bus.long_held);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.sp == bus.short_pulse && e.lp == bus.long_pulse &&
                    e.rp == bus.repeat_pulse && e.lh == bus.long_held) begin
                    n_pass++;
                end else begin
                    $display("FAIL event: got cycle %0d sp=%b lp=%b rp=%b lh=%b, required cycle %0d sp=%b lp=%b rp=%b lh=%b",
                             cyc, bus.short_pulse, bus.long_pulse, bus.repeat_pulse, bus.long_held,
                             e.cyc, e.sp, e.lp, e.rp, e.lh);
                end
            end
        end
        prev_lh = bus.long_held;
    end

    task automatic tick();
        @(negedge clk_10000Hz);
        #1;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (bus.short_pulse == 0 && bus.long_pulse == 0 && bus.long_held == 0 && bus.repeat_pulse == 0)
            n_pass++;
        else
            $display("FAIL %s: got sp=%b lp=%b lh=%b rp=%b, required all 0", name,
                     bus.short_pulse, bus.long_pulse, bus.long_held, bus.repeat_pulse);
    endtask

    // Hold the keys in mask m for n cycles, with expectations derived from
    // the press timing: key -> ks takes 2 clk, count n is visible at r+2+n,
    // long_held rises one cycle after the count reaches C_LONG, and the
    // release pulse appears 3 clk after key_in falls.
    task automatic press(input logic [1:0] m, input int n);
        int r;
        r = cyc;
        if (n > C_LONG) add_ev(r + C_LONG + 3, 2'b00, 2'b00, 2'b00, m);
`ifdef PRESS_REPEAT_EN
        for (int k = C_LONG; k <= n; k += C_REP)
            add_ev(r + 2 + k, 2'b00, 2'b00, m, (k > C_LONG) ? m : 2'b00);
`endif
        if (n >= C_LONG)       add_ev(r + n + 3, 2'b00, m, 2'b00, 2'b00);
        else if (n >= C_SHORT) add_ev(r + n + 3, m, 2'b00, 2'b00, 2'b00);
        bus.key_in = bus.key_in | m;
        repeat (n) tick();
        bus.key_in = bus.key_in & ~m;
        repeat (12) tick();
    endtask

    initial begin
        bus.key_in = 2'b00;
        rst_n      = 1'b0;
        repeat (3) tick();
        check_idle("reset_state");
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("after_reset");

        press(2'b01, 2);     // glitch: no event
        press(2'b01, 10);    // short
        press(2'b10, 25);    // long with long_held
        press(2'b01, 300);   // counter saturation, still long
        press(2'b11, 10);    // simultaneous shorts
        press(2'b10, 3);     // shortest valid short
        press(2'b10, 19);    // longest short
        press(2'b10, 20);    // shortest long, long_held never rises
        press(2'b10, 21);    // long_held for one cycle

        // Reset mid-press drops the press; the 3 cycles after reset are a glitch.
        bus.key_in = 2'b01;
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        check_idle("mid_press_reset");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        bus.key_in = 2'b00;
        repeat (12) tick();

`ifdef PRESS_REPEAT_EN
        press(2'b01, 32);    // repeats at count 20, 25, 30
`endif

        repeat (5) tick();
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL pending_events: got %0d expected events still queued, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_press_classifier
`default_nettype wire
